// File: rtl/bus_arb_mux.sv
// ---------------------------------------------------------------------------
// bus_arb_mux
//
// Arbitrating N:1 multiplexer with a single registered output slot. Each
// cycle the arbiter picks one requesting channel. If the output slot can
// take a new beat, that channel's word and index are captured into the
// output register. The slot accepts a new beat in the same cycle that the
// downstream side drains the old one, so a steady stream of requests moves
// at one beat per clock.
//
// Configuration macro:
//   BUS_ARB_RR_EN  defined   -> round-robin arbitration. A pointer records
//                               the channel after the last one granted.
//                  undefined -> fixed priority, the lowest index wins, and
//                               no pointer register is built.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   [NUM_CH]            per-channel request
//   in_data    in   [NUM_CH*DATA_WIDTH] packed words, channel i at
//                                       [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready   out  [NUM_CH]            per-channel accept, one-hot or zero
//   out_valid  out                      output register holds a beat
//   out_data   out  [DATA_WIDTH]        registered selected word
//   out_ch     out  [CH_W]              channel that supplied out_data
//   out_ready  in                       downstream accept
// ---------------------------------------------------------------------------
module bus_arb_mux #(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_WIDTH = 16,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]              out_ch,
  input  logic                         out_ready
);

  logic                  slot_avail;
  logic                  any_valid;
  logic                  xfer;
  logic [NUM_CH-1:0]     grant;
  logic [CH_W-1:0]       grant_idx;
  logic [DATA_WIDTH-1:0] ch_data [NUM_CH];

  // Split the packed input bus into one word per channel.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_data[g] = in_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // The slot is free when it is empty, or when its beat leaves this cycle.
  assign slot_avail = !out_valid || out_ready;
  assign any_valid  = |in_valid;

  // Accept a beat only when there is somewhere to put it. The reset term
  // keeps every accept low while the block is held in reset.
  assign in_ready = (reset_n && slot_avail && any_valid) ? grant : '0;
  assign xfer     = |(in_valid & in_ready);

`ifdef BUS_ARB_RR_EN
  logic [CH_W-1:0] ptr;

  // Round-robin search. The candidates are visited from the farthest to
  // the nearest relative to the pointer. Each valid candidate overwrites
  // the previous choice, so the first valid channel at or above the pointer,
  // with wrap-around, is the one that wins.
  always_comb begin
    int            cand;
    logic [CH_W-1:0] ci;
    grant     = '0;
    grant_idx = '0;
    cand      = 0;
    ci        = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % NUM_CH;
      ci   = CH_W'(cand);
      if (in_valid[ci]) begin
        grant     = '0;
        grant[ci] = 1'b1;
        grant_idx = ci;
      end
    end
  end

  // The pointer moves past a channel only after that channel actually
  // transfers. A request that is withdrawn before it is granted leaves
  // the pointer where it was.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  // Fixed priority. The scan runs from high index to low, so the lowest
  // valid index is the last one written and wins.
  always_comb begin
    logic [CH_W-1:0] ci;
    grant     = '0;
    grant_idx = '0;
    ci        = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      ci = CH_W'(i);
      if (in_valid[ci]) begin
        grant     = '0;
        grant[ci] = 1'b1;
        grant_idx = ci;
      end
    end
  end
`endif

  // Output slot. A granted transfer loads a new beat. A free slot with no
  // transfer becomes empty. A stalled slot keeps its word and index stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[grant_idx];
      out_ch    <= grant_idx;
    end else if (slot_avail) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/bus_arb_mux.md
BUS_ARB_MUX -- requirements
Module: bus_arb_mux

Interface
REQ-001 Parameter NUM_CH, default 4, number of input channels (legal range 2..8).
REQ-002 Parameter DATA_WIDTH, default 16, width of each channel's data word.
REQ-003 Derived CH_W = clog2(NUM_CH); this is the width of the channel index.
REQ-004 clk  input  1  the single clock; all state changes on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  NUM_CH  per-channel request; bit i belongs to channel i.
REQ-007 in_data  input  NUM_CH*DATA_WIDTH  packed data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 in_ready  output  NUM_CH  per-channel accept; it is one-hot or zero.
REQ-009 out_valid  output  1  the output register holds a beat.
REQ-010 out_data  output  DATA_WIDTH  registered selected data.
REQ-011 out_ch  output  CH_W  index of the channel that supplied out_data.
REQ-012 out_ready  input  1  downstream accept.

Function
REQ-013 A transfer on channel i SHALL occur when in_valid[i] and in_ready[i] are both high at the rising edge; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-014 The output slot SHALL be available when out_valid is 0, or when out_valid and out_ready are both 1 (pass-through pipelining, no bubble).
REQ-015 in_ready SHALL be combinational: zero unless the slot is available and at least one in_valid bit is set; otherwise it SHALL be exactly the grant bit chosen by the arbiter.
REQ-016 On an input transfer, out_data and out_ch SHALL load the granted channel's data and index, and out_valid SHALL be 1 on the next cycle; latency is 1 cycle.
REQ-017 When the slot is available and no channel is valid, out_valid SHALL go to 0 on the next edge.
REQ-018 While out_valid is 1 and out_ready is 0, out_data and out_ch SHALL hold stable and all in_ready bits SHALL be 0.
REQ-019 The arbiter SHALL never grant a channel whose in_valid bit is 0.
REQ-020 Sustained throughput SHALL be one beat per cycle while out_ready is held at 1.
REQ-021 in_valid deasserted before it is granted SHALL be tolerated: no transfer occurs and no state changes for that channel.

Reset
REQ-022 While reset_n is low, all outputs and state SHALL be forced asynchronously: out_valid=0, out_data=0, out_ch=0, arbitration pointer=0.
REQ-023 in_ready SHALL be all zero while reset_n is low.
REQ-024 Reset asserted mid-transfer SHALL discard the held beat; the first grant after release SHALL follow the reset pointer.

Configuration
REQ-025 Macro BUS_ARB_RR_EN defined: round-robin arbitration.
- The pointer holds the index after the last granted channel, mod NUM_CH.
- The search starts at the pointer and moves upward with wrap-around.
- The pointer updates only on an input transfer.
REQ-026 Macro BUS_ARB_RR_EN undefined: fixed priority, lowest index wins; no pointer register is instantiated.

Verification
REQ-027 Reset check (NUM_CH=4, DATA_WIDTH=16): pulse reset_n low asynchronously between edges -> out_valid=0, out_data=0x0000, out_ch=0, in_ready=4'b0000 immediately.
REQ-028 Single request: in_valid=4'b0100, ch2 data 0xBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=0xBEEF, out_ch=2.
REQ-029 Backpressure: out_valid=1 holding 0x1234, out_ready=0 for 3 cycles with in_valid=4'b1111 -> in_ready=0 and out_data=0x1234 on all 3 cycles.
REQ-030 Round-robin (BUS_ARB_RR_EN defined): in_valid=4'b1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-031 Fixed priority (BUS_ARB_RR_EN undefined): in_valid=4'b1010 held -> out_ch=1 every cycle and channel 3 is never granted.
REQ-032 Drain: single beat accepted, then in_valid=0 with out_ready=1 -> out_valid 1 for one cycle, then 0.
